dma_read_arbiter: RTL and testbench



---
 rtl/dma_read_arbiter_pkg.sv | 35 +++
 rtl/dma_read_arbiter_picker.sv | 38 +++
 rtl/dma_read_arbiter.sv | 89 ++++++++
 tb/tb_dma_read_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_read_arbiter_pkg.sv
// dma_read_arbiter_pkg: DMA read-channel bundle types and the arbiter state encoding
package dma_read_arbiter_pkg;
  localparam int CLADDR_WIDTH = 32;
  localparam int CLDATA_WIDTH = 64;
  typedef struct packed {
    logic [31:0] reg0;
    logic [31:0] reg1;
  } t_dma_regs;
  typedef struct packed {
    logic                    start;
    logic                    async;
    t_dma_regs               regs;
    logic [CLADDR_WIDTH-1:0] addr;
  } t_dma_control;
  typedef struct packed {
    logic idle;
    logic active;
    logic done;
  } t_dma_status;
  typedef struct packed {
    logic                    re;
    logic [CLADDR_WIDTH-1:0] raddr;
  } t_dma_tx_read;
  typedef struct packed {
    logic                    rvalid;
    logic                    ralmostfull;
    logic [CLDATA_WIDTH-1:0] rdata;
  } t_dma_rx_read;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_START   = 2'd1,
    ARB_BUSY    = 2'd2,
    ARB_RELEASE = 2'd3
  } t_arbstate;
endpackage

// File: rtl/dma_read_arbiter_picker.sv
// dma_rr_picker: round-robin request picker; DMA_ARB_FIXED_PRIORITY_EN makes it lowest-index-wins
module dma_rr_picker #(
  parameter int NUM_CLIENTS      = 4,
  parameter int LOG2_NUM_CLIENTS = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0]      req_i,
  input  logic [LOG2_NUM_CLIENTS-1:0] ptr_i,
  output logic [NUM_CLIENTS-1:0]      gnt_o,
  output logic [LOG2_NUM_CLIENTS-1:0] idx_o
);
`ifdef DMA_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  // scan from the top down so the lowest requesting index is left standing
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--)
      if (req_i[k]) begin
        gnt_o        = '0;
        gnt_o[k]     = 1'b1;
        idx_o        = LOG2_NUM_CLIENTS'(k);
      end
  end
`else
  // scan from farthest to nearest after the pointer so the nearest requester is left standing
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--)
      if (req_i[(int'(ptr_i) + k) % NUM_CLIENTS]) begin
        gnt_o                                   = '0;
        gnt_o[(int'(ptr_i) + k) % NUM_CLIENTS]  = 1'b1;
        idx_o = LOG2_NUM_CLIENTS'((int'(ptr_i) + k) % NUM_CLIENTS);
      end
  end
`endif
endmodule

// File: rtl/dma_read_arbiter.sv
// dma_read_arbiter: grants one client the shared read DMA per transfer; DMA_ARB_FIXED_PRIORITY_EN selects fixed priority
module dma_read_arbiter
  import dma_read_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS      = 4,
  parameter int LOG2_NUM_CLIENTS = $clog2(NUM_CLIENTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  t_dma_control                client_control [NUM_CLIENTS],
  output t_dma_status                 client_status  [NUM_CLIENTS],
  input  t_dma_tx_read                client_tx_read [NUM_CLIENTS],
  output t_dma_rx_read                client_rx_read [NUM_CLIENTS],
  output t_dma_control                dma_control,
  input  t_dma_status                 dma_status,
  output t_dma_tx_read                dma_tx_read,
  input  t_dma_rx_read                dma_rx_read,
  output logic [LOG2_NUM_CLIENTS-1:0] owner
);
  t_arbstate                   state_q, state_d;
  t_dma_control                ctl_q, ctl_d;
  logic [LOG2_NUM_CLIENTS-1:0] owner_q, owner_d, ptr, pick_idx;
  logic [NUM_CLIENTS-1:0]      req, pick_gnt;
  logic                        grab, busy, held, unused_status;
  assign unused_status = dma_status.idle ^ dma_status.active;
  assign busy  = state_q == ARB_BUSY;
  assign held  = state_q == ARB_START || busy;
  assign grab  = state_q == ARB_IDLE && |pick_gnt;
  assign owner = owner_q;
  // gather the start bits as the request vector
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) req[i] = client_control[i].start;
  end
`ifdef DMA_ARB_FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  logic [LOG2_NUM_CLIENTS-1:0] ptr_q;
  assign ptr = ptr_q;
  // the pointer remembers the last winner; reset points at the top so client 0 wins first
  always_ff @(posedge clk)
    if (reset) ptr_q <= LOG2_NUM_CLIENTS'(NUM_CLIENTS - 1);
    else if (grab) ptr_q <= pick_idx;
`endif
  dma_rr_picker #(.NUM_CLIENTS(NUM_CLIENTS), .LOG2_NUM_CLIENTS(LOG2_NUM_CLIENTS)) u_picker (
    .req_i(req),
    .ptr_i(ptr),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );
  // transfer lifecycle: pick, pulse start, wait for done, one release cycle
  always_comb begin
    state_d = state_q == ARB_IDLE  ? (grab ? ARB_START : ARB_IDLE) :
              state_q == ARB_START ? ARB_BUSY :
              busy                 ? (dma_status.done ? ARB_RELEASE : ARB_BUSY) : ARB_IDLE;
    ctl_d   = grab ? client_control[pick_idx] : ctl_q;
    owner_d = grab ? pick_idx : owner_q;
  end
  // state, latched request and owner registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ARB_IDLE;
      ctl_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      owner_q <= owner_d;
    end
  assign dma_control = state_q == ARB_START ? ctl_q : '0;
  assign dma_tx_read = busy ? client_tx_read[owner_q] : '0;
  // per-client status and read-response demux; data is broadcast, only rvalid is steered
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      client_status[i] = '{
        idle:   !((held || state_q == ARB_RELEASE) && owner_q == LOG2_NUM_CLIENTS'(i)),
        active: held && owner_q == LOG2_NUM_CLIENTS'(i),
        done:   state_q == ARB_RELEASE && owner_q == LOG2_NUM_CLIENTS'(i)
      };
      client_rx_read[i] = '{
        rvalid:      dma_rx_read.rvalid && busy && owner_q == LOG2_NUM_CLIENTS'(i),
        ralmostfull: dma_rx_read.ralmostfull,
        rdata:       dma_rx_read.rdata
      };
    end
  end
  // the engine reporting done while it is still being started is a protocol violation
  assert property (@(posedge clk) disable iff (reset) state_q == ARB_START |-> !dma_status.done);
endmodule

// File: tb/tb_dma_read_arbiter.sv
module tb_dma_read_arbiter;
  import dma_read_arbiter_pkg::*;
  localparam int N = 4;
  localparam int L = 2;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  t_dma_control client_control [N];
  t_dma_status  client_status  [N];
  t_dma_tx_read client_tx_read [N];
  t_dma_rx_read client_rx_read [N];
  t_dma_control dma_control;
  t_dma_status  dma_status;
  t_dma_tx_read dma_tx_read;
  t_dma_rx_read dma_rx_read;
  logic [L-1:0] owner;

  always #5 clk = ~clk;

  dma_read_arbiter #(.NUM_CLIENTS(N), .LOG2_NUM_CLIENTS(L)) dut (
    .clk(clk), .reset(reset),
    .client_control(client_control), .client_status(client_status),
    .client_tx_read(client_tx_read), .client_rx_read(client_rx_read),
    .dma_control(dma_control), .dma_status(dma_status),
    .dma_tx_read(dma_tx_read), .dma_rx_read(dma_rx_read),
    .owner(owner)
  );

  int n_cmp = 0;
  int n_bad = 0;
  // model: a transfer is described by the cycle its start pulse shows and the cycle done was seen
  int cyc = 0;
  int m_start_at = -1;
  int m_done_at = -1;
  int m_own = 0;
  int m_last = N - 1;
  bit m_valid = 1'b0;
  t_dma_control m_ctl = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_act(input int i);
    return m_start_at >= 0 && m_own == i && cyc >= m_start_at && (m_done_at < 0 || cyc <= m_done_at);
  endfunction
  function automatic bit m_busy();
    return m_start_at >= 0 && cyc > m_start_at && (m_done_at < 0 || cyc <= m_done_at);
  endfunction
  function automatic bit m_dn(input int i);
    return m_done_at >= 0 && m_own == i && cyc == m_done_at + 1;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_start_at = -1; m_done_at = -1; m_own = 0; m_last = N - 1; m_valid = 1'b1;
    end else if (m_start_at < 0 || (m_done_at >= 0 && cyc >= m_done_at + 2)) begin
      int w = -1;
`ifdef DMA_ARB_FIXED_PRIORITY_EN
      for (int k = 0; k < N && w < 0; k++) if (client_control[k].start) w = k;
`else
      for (int k = 1; k <= N && w < 0; k++) if (client_control[(m_last + k) % N].start) w = (m_last + k) % N;
`endif
      if (w >= 0) begin
        m_own = w; m_last = w; m_start_at = cyc + 1; m_done_at = -1; m_ctl = client_control[w];
      end
    end else if (m_done_at < 0 && cyc > m_start_at && dma_status.done) m_done_at = cyc;
    cyc++;
  endtask

  task automatic compare();
    t_dma_control ec;
    t_dma_tx_read et;
    t_dma_status  es;
    t_dma_rx_read er;
    if (!m_valid) return;
    ec = (m_start_at >= 0 && cyc == m_start_at) ? m_ctl : '0;
    chk("dma_control", 128'(dma_control), 128'(ec));
    et = m_busy() ? client_tx_read[m_own] : '0;
    chk("dma_tx_read", 128'(dma_tx_read), 128'(et));
    chk("owner", 128'(owner), 128'(m_own));
    for (int i = 0; i < N; i++) begin
      es = '{idle: !m_act(i) && !m_dn(i), active: m_act(i), done: m_dn(i)};
      chk($sformatf("client_status[%0d]", i), 128'(client_status[i]), 128'(es));
      er = dma_rx_read;
      er.rvalid = dma_rx_read.rvalid && m_busy() && m_own == i;
      chk($sformatf("client_rx_read[%0d]", i), 128'(client_rx_read[i]), 128'(er));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic look();
    @(negedge clk);
    compare();
  endtask

  task automatic rnd_drive();
    for (int i = 0; i < N; i++) begin
      if (client_control[i].start && (m_act(i) || $urandom_range(31) == 0)) client_control[i].start = 1'b0;
      else if (!client_control[i].start && !m_act(i) && $urandom_range(3) == 0)
        client_control[i] = '{start: 1'b1, async: 1'($urandom), regs: '{reg0: $urandom, reg1: $urandom}, addr: $urandom};
      client_tx_read[i] = '{re: 1'($urandom), raddr: $urandom};
    end
    dma_rx_read = '{rvalid: 1'($urandom), ralmostfull: 1'($urandom), rdata: {$urandom, $urandom}};
    dma_status = '{idle: 1'($urandom), active: 1'($urandom), done: cyc != m_start_at && $urandom_range(4) == 0};
  endtask

  initial begin
    int w, o, c1, co, dc;
`ifdef DMA_ARB_FIXED_PRIORITY_EN
    int exp_order [4] = '{0, 0, 1, 3};
    int exp_cont  [4] = '{1, 1, 1, 1};
`else
    int exp_order [4] = '{0, 1, 3, 0};
    int exp_cont  [4] = '{1, 3, 1, 3};
`endif
    for (int i = 0; i < N; i++) begin
      client_control[i] = '0;
      client_tx_read[i] = '0;
    end
    dma_status = '0;
    dma_rx_read = '0;
    // reset state
    tick(); tick(); look();
    for (int i = 0; i < N; i++) begin
      chk("reset status", 128'(client_status[i]), 128'(3'b100));
      chk("reset rvalid", 128'(client_rx_read[i].rvalid), 128'(0));
    end
    chk("reset owner", 128'(owner), 128'(0));
    chk("reset dma_control", 128'(dma_control), 128'(0));
    chk("reset dma_tx_read", 128'(dma_tx_read), 128'(0));
    // single request from client 2
    reset = 1'b0;
    client_control[2] = '{start: 1'b1, async: 1'b0, regs: '{reg0: 32'd8, reg1: 32'd0}, addr: 32'h100};
    tick(); look();
    chk("c2 start", 128'(dma_control.start), 128'(1));
    chk("c2 addr", 128'(dma_control.addr), 128'(32'h100));
    chk("c2 reg0", 128'(dma_control.regs.reg0), 128'(8));
    chk("c2 active", 128'(client_status[2].active), 128'(1));
    chk("c0 idle", 128'(client_status[0]), 128'(3'b100));
    chk("c3 idle", 128'(client_status[3]), 128'(3'b100));
    client_control[2].start = 1'b0;
    tick(); look();
    dma_status.done = 1'b1;
    tick();
    dma_status.done = 1'b0;
    look();
    chk("c2 done", 128'(client_status[2].done), 128'(1));
    tick();
    // clients 0,1,3 compete; rvalid steering and tx gating checked along the way
    reset = 1'b1;
    tick();
    reset = 1'b0;
    look();
    for (int i = 0; i < N; i++)
      if (i != 2) client_control[i] = '{start: 1'b1, async: 1'(i), regs: '{reg0: 32'(i), reg1: 32'd1}, addr: 32'(i * 16)};
    tick();
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (w < 10) begin
        look();
        if (dma_control.start) break;
        tick();
        w++;
      end
      chk("grant wait", 128'(w < 10), 128'(1));
      chk($sformatf("grant order[%0d]", n), 128'(owner), 128'(exp_order[n]));
      o = exp_order[n];
      client_control[o].start = 1'b0;
      tick();
      if (o == 1) begin
        c1 = 0; co = 0;
        for (int k = 0; k < 4; k++) begin
          dma_rx_read = '{rvalid: 1'b1, ralmostfull: 1'b0, rdata: 64'(10 + k)};
          look();
          c1 += int'(client_rx_read[1].rvalid);
          for (int j = 0; j < N; j++) if (j != 1) co += int'(client_rx_read[j].rvalid);
          chk("rdata broadcast", 128'(client_rx_read[0].rdata), 128'(10 + k));
          tick();
        end
        dma_rx_read = '0;
        chk("owner rvalid beats", 128'(c1), 128'(4));
        chk("other rvalid beats", 128'(co), 128'(0));
      end
      if (o == 3) begin
        client_tx_read[0] = '{re: 1'b1, raddr: 32'h40};
        client_tx_read[3] = '0;
        look();
        chk("non-owner re", 128'(dma_tx_read.re), 128'(0));
        tick();
        client_tx_read[3] = '{re: 1'b1, raddr: 32'h80};
        look();
        chk("owner tx", 128'(dma_tx_read), 128'({1'b1, 32'h80}));
        tick();
        client_tx_read[0] = '0;
        client_tx_read[3] = '0;
      end
      dma_status.done = 1'b1;
      look();
      tick();
      dma_status.done = 1'b0;
      if (n == 0) client_control[0].start = 1'b1;
      dc = 0;
      for (int k = 0; k < 2; k++) begin
        look();
        dc += int'(client_status[o].done);
        tick();
      end
      chk("done pulse width", 128'(dc), 128'(1));
    end
    // clients 1 and 3 hold start continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) client_control[i] = '0;
    client_control[1] = '{start: 1'b1, async: 1'b1, regs: '{reg0: 32'd1, reg1: 32'd2}, addr: 32'h11};
    client_control[3] = '{start: 1'b1, async: 1'b0, regs: '{reg0: 32'd3, reg1: 32'd4}, addr: 32'h33};
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (w < 10) begin
        look();
        if (dma_control.start) break;
        tick();
        w++;
      end
      chk("hold grant wait", 128'(w < 10), 128'(1));
      chk($sformatf("hold order[%0d]", n), 128'(owner), 128'(exp_cont[n]));
      tick();
      dma_status.done = 1'b1;
      look();
      tick();
      dma_status.done = 1'b0;
    end
    client_control[1].start = 1'b0;
    client_control[3].start = 1'b0;
    // reset in the middle of a transfer
    client_control[2].start = 1'b1;
    w = 0;
    while (w < 10) begin
      look();
      if (dma_control.start) break;
      tick();
      w++;
    end
    chk("mid grant wait", 128'(w < 10), 128'(1));
    client_control[2].start = 1'b0;
    tick();
    reset = 1'b1;
    look();
    tick();
    reset = 1'b0;
    client_control[0].start = 1'b1;
    client_control[2].start = 1'b1;
    look();
    chk("abandon start", 128'(dma_control.start), 128'(0));
    for (int i = 0; i < N; i++) chk("abandon idle", 128'(client_status[i]), 128'(3'b100));
    tick();
    look();
    chk("post-reset start", 128'(dma_control.start), 128'(1));
    chk("post-reset winner", 128'(owner), 128'(0));
    tick();
    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rnd_drive();
      look();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
